// File: rtl/key_edge_pkg.sv
// Shared register addresses and debounce FSM state encoding for key_edge_ctrl.
package key_edge_pkg;

   localparam logic [1:0] ADDR_DATA = 2'd0;
   localparam logic [1:0] ADDR_MASK = 2'd2;
   localparam logic [1:0] ADDR_EDGE = 2'd3;

   typedef enum logic {
      STABLE  = 1'b0,
      PENDING = 1'b1
   } deb_state_t;

endpackage

// File: rtl/key_debounce.sv
// Per-key two-flop synchronizer plus optional debounce FSM (enabled by KEY_DEBOUNCE_EN).
// 'armed' goes high once the flushed synchronizer has seen the key released.
module key_debounce
   import key_edge_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
   input  logic clk,
   input  logic reset,
   input  logic key_n,
   output logic deb,
   output logic armed
);

   logic [1:0] sync_q;
   logic [1:0] flush_q;
   logic       sync;

   assign sync = sync_q[1];

   // flush_q[1] rises on the same edge sync first reflects the pin, so a key
   // held through reset is never seen as released and cannot arm.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q  <= 2'b11;
         flush_q <= 2'b00;
         armed   <= 1'b0;
      end else begin
         sync_q  <= {sync_q[0], key_n};
         flush_q <= {flush_q[0], 1'b1};
         if (flush_q[1] && sync)
            armed <= 1'b1;
      end
   end

`ifdef KEY_DEBOUNCE_EN
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   deb_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             deb_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= STABLE;
         cnt_q   <= '0;
         deb     <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         deb     <= deb_d;
      end
   end

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      deb_d   = deb;
      unique case (state_q)
         STABLE: begin
            if (sync != deb) begin
               state_d = PENDING;
               cnt_d   = '0;
            end
         end
         PENDING: begin
            if (sync == deb) begin
               state_d = STABLE;
            end else if (cnt_q == CNT_LAST) begin
               deb_d   = sync;
               state_d = STABLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
      endcase
   end
`else
   assign deb = sync;
`endif

endmodule

// File: rtl/key_edge_ctrl.sv
// Avalon-MM key controller: debounced key levels, sticky press capture, maskable irq.
// Debounce counters are built only when KEY_DEBOUNCE_EN is defined.
module key_edge_ctrl
   import key_edge_pkg::*;
#(
   parameter int N_KEYS          = 2,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        address,
   input  logic              read,
   input  logic              write,
   input  logic [31:0]       writedata,
   output logic [31:0]       readdata,
   output logic              irq,
   input  logic [N_KEYS-1:0] in_port
);

   logic [N_KEYS-1:0] deb;
   logic [N_KEYS-1:0] deb_q;
   logic [N_KEYS-1:0] armed;
   logic [N_KEYS-1:0] press;
   logic [N_KEYS-1:0] w1c;
   logic [N_KEYS-1:0] edge_cap;
   logic [N_KEYS-1:0] irq_mask;
   logic [31:0]       rdata_d;
   logic              unused_wdata;

   for (genvar k = 0; k < N_KEYS; k++) begin : g_key
      key_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .CNT_W           (CNT_W)
      ) u_debounce (
         .clk   (clk),
         .reset (reset),
         .key_n (in_port[k]),
         .deb   (deb[k]),
         .armed (armed[k])
      );
   end

   assign press        = deb_q & ~deb & armed;
   assign w1c          = (write && address == ADDR_EDGE) ? writedata[N_KEYS-1:0] : '0;
   assign unused_wdata = ^writedata[31:N_KEYS];

   always_comb begin
      rdata_d = '0;
      case (address)
         ADDR_DATA: rdata_d[N_KEYS-1:0] = ~deb;
         ADDR_MASK: rdata_d[N_KEYS-1:0] = irq_mask;
         ADDR_EDGE: rdata_d[N_KEYS-1:0] = edge_cap;
         default:   rdata_d = '0;
      endcase
   end

   // A press arriving with a W1C of the same bit survives: the set is OR-ed in last.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         deb_q    <= '1;
         edge_cap <= '0;
         irq_mask <= '0;
         irq      <= 1'b0;
         readdata <= '0;
      end else begin
         deb_q    <= deb;
         edge_cap <= (edge_cap & ~w1c) | press;
         if (write && address == ADDR_MASK)
            irq_mask <= writedata[N_KEYS-1:0];
         irq <= |(edge_cap & irq_mask);
         if (read)
            readdata <= rdata_d;
      end
   end

endmodule

// File: tb/tb_key_edge_ctrl.sv
// Directed bench for key_edge_ctrl with DEBOUNCE_CYCLES = 4; follows KEY_DEBOUNCE_EN.
`timescale 1ns/1ps
module tb_key_edge_ctrl;
   import key_edge_pkg::*;

   localparam int N_KEYS = 2;
   localparam int DEB    = 4;
`ifdef KEY_DEBOUNCE_EN
   localparam int          PRESS_LAT   = DEB + 4;
   localparam logic [31:0] GLITCH_EDGE = 32'h0;
`else
   localparam int          PRESS_LAT   = 3;
   localparam logic [31:0] GLITCH_EDGE = 32'h1;
`endif

   logic              clk = 1'b0;
   logic              reset;
   logic [1:0]        address;
   logic              read;
   logic              write;
   logic [31:0]       writedata;
   logic [31:0]       readdata;
   logic              irq;
   logic [N_KEYS-1:0] in_port;

   always #5 clk = ~clk;

   key_edge_ctrl #(
      .N_KEYS          (N_KEYS),
      .DEBOUNCE_CYCLES (DEB),
      .CNT_W           ($clog2(DEB))
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .address   (address),
      .read      (read),
      .write     (write),
      .writedata (writedata),
      .readdata  (readdata),
      .irq       (irq),
      .in_port   (in_port)
   );

   typedef enum logic [1:0] {OP_RD, OP_WR, OP_RW} op_t;
   typedef struct {
      op_t         op;
      logic [1:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;

   vec_t        vecs [16];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          lat;
   logic [31:0] d;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] data);
      address = a;
      read    = 1'b1;
      tick();
      read    = 1'b0;
      data    = readdata;
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] data);
      address   = a;
      writedata = data;
      write     = 1'b1;
      tick();
      write     = 1'b0;
   endtask

   task automatic rd_check(input string name, input logic [1:0] a, input logic [31:0] exp);
      logic [31:0] v;
      rd(a, v);
      check(name, v, exp);
   endtask

   initial begin
      // Register-map vectors applied with both keys released.
      vecs[0]  = '{OP_RD, ADDR_DATA, 32'h0,         32'h0};
      vecs[1]  = '{OP_RD, ADDR_MASK, 32'h0,         32'h0};
      vecs[2]  = '{OP_RD, 2'd1,      32'h0,         32'h0};
      vecs[3]  = '{OP_RD, ADDR_EDGE, 32'h0,         32'h0};
      vecs[4]  = '{OP_WR, ADDR_MASK, 32'hFFFF_FFFD, 32'h0};
      vecs[5]  = '{OP_RD, ADDR_MASK, 32'h0,         32'h1};
      vecs[6]  = '{OP_RW, ADDR_MASK, 32'h0000_0002, 32'h1};
      vecs[7]  = '{OP_RD, ADDR_MASK, 32'h0,         32'h2};
      vecs[8]  = '{OP_WR, 2'd1,      32'hFFFF_FFFF, 32'h0};
      vecs[9]  = '{OP_RD, 2'd1,      32'h0,         32'h0};
      vecs[10] = '{OP_WR, ADDR_DATA, 32'hFFFF_FFFF, 32'h0};
      vecs[11] = '{OP_RD, ADDR_DATA, 32'h0,         32'h0};
      vecs[12] = '{OP_WR, ADDR_EDGE, 32'hFFFF_FFFF, 32'h0};
      vecs[13] = '{OP_RD, ADDR_EDGE, 32'h0,         32'h0};
      vecs[14] = '{OP_WR, ADDR_MASK, 32'h0,         32'h0};
      vecs[15] = '{OP_RD, ADDR_MASK, 32'h0,         32'h0};

      reset     = 1'b1;
      address   = '0;
      read      = 1'b0;
      write     = 1'b0;
      writedata = '0;
      in_port   = 2'b11;
      idle(2);
      check("reset_readdata", readdata, 32'h0);
      check("reset_irq", {31'b0, irq}, 32'h0);
      reset = 1'b0;
      idle(4);

      foreach (vecs[i]) begin
         case (vecs[i].op)
            OP_RD: begin
               rd(vecs[i].addr, d);
               check($sformatf("vec%0d_read", i), d, vecs[i].exp);
            end
            OP_WR: wr(vecs[i].addr, vecs[i].wdata);
            default: begin
               address   = vecs[i].addr;
               writedata = vecs[i].wdata;
               read      = 1'b1;
               write     = 1'b1;
               tick();
               read      = 1'b0;
               write     = 1'b0;
               check($sformatf("vec%0d_rdwr", i), readdata, vecs[i].exp);
            end
         endcase
      end
      check("irq_idle", {31'b0, irq}, 32'h0);

      // Press key0 and poll EDGE every cycle to find the capture edge.
      in_port = 2'b10;
      address = ADDR_EDGE;
      read    = 1'b1;
      lat     = -1;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (lat < 0 && readdata[0]) lat = i - 1;
      end
      read = 1'b0;
      check("press_latency", lat, PRESS_LAT);
      rd_check("data_key0_pressed", ADDR_DATA, 32'h1);
      rd_check("edge_key0", ADDR_EDGE, 32'h1);
      wr(ADDR_EDGE, 32'h1);
      rd_check("edge_w1c", ADDR_EDGE, 32'h0);
      in_port = 2'b11;
      idle(12);
      rd_check("data_released", ADDR_DATA, 32'h0);
      rd_check("release_not_captured", ADDR_EDGE, 32'h0);

      // Three-cycle glitch on key0.
      in_port = 2'b10;
      idle(3);
      in_port = 2'b11;
      idle(12);
      rd_check("glitch_edge", ADDR_EDGE, GLITCH_EDGE);
      rd_check("glitch_data", ADDR_DATA, 32'h0);
      wr(ADDR_EDGE, 32'h3);

      // Interrupt set and cleared through W1C.
      wr(ADDR_MASK, 32'h3);
      in_port = 2'b01;
      idle(12);
      check("irq_key1", {31'b0, irq}, 32'h1);
      rd_check("edge_key1", ADDR_EDGE, 32'h2);
      wr(ADDR_EDGE, 32'h2);
      tick();
      check("irq_cleared", {31'b0, irq}, 32'h0);
      rd_check("edge_after_clear", ADDR_EDGE, 32'h0);
      in_port = 2'b11;
      idle(12);

      // W1C of bit 0 on the same edge the key0 press sets it.
      in_port = 2'b10;
      idle(PRESS_LAT - 1);
      wr(ADDR_EDGE, 32'h1);
      tick();
      check("irq_after_collision", {31'b0, irq}, 32'h1);
      rd_check("w1c_collision", ADDR_EDGE, 32'h1);
      wr(ADDR_EDGE, 32'h1);
      rd_check("w1c_after_collision", ADDR_EDGE, 32'h0);
      in_port = 2'b11;
      idle(12);

      // MASK write on the same edge the key1 press is captured.
      wr(ADDR_MASK, 32'h0);
      in_port = 2'b01;
      idle(PRESS_LAT - 1);
      wr(ADDR_MASK, 32'h2);
      tick();
      check("irq_mask_edge_same_cycle", {31'b0, irq}, 32'h1);
      rd_check("edge_mask_same_cycle", ADDR_EDGE, 32'h2);
      rd_check("mask_same_cycle", ADDR_MASK, 32'h2);
      wr(ADDR_EDGE, 32'h3);
      in_port = 2'b11;
      idle(12);

      // Reset while key0 is mid-debounce, pin held low through reset exit.
      in_port = 2'b10;
      idle(4);
      reset = 1'b1;
      #2;
      check("async_reset_irq", {31'b0, irq}, 32'h0);
      tick();
      reset = 1'b0;
      idle(20);
      rd_check("no_edge_after_reset", ADDR_EDGE, 32'h0);
      rd_check("data_held_after_reset", ADDR_DATA, 32'h1);
      rd_check("mask_after_reset", ADDR_MASK, 32'h0);
      in_port = 2'b11;
      idle(12);
      in_port = 2'b10;
      idle(12);
      rd_check("repress_after_reset", ADDR_EDGE, 32'h1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
